// File: rtl/dmem_if.sv
// Load/store request-response bundle between the pipeline MEM stage (master)
// and the data-memory responder (slave).
interface dmem_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     wr_data;
    logic [2:0]            func3;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rd_data;
    logic                  misaligned_err;

    modport master (
        output req_valid, MemRead, MemWrite, addr, wr_data, func3,
        input  req_ready, rsp_valid, rd_data, misaligned_err
    );

    modport slave (
        input  req_valid, MemRead, MemWrite, addr, wr_data, func3,
        output req_ready, rsp_valid, rd_data, misaligned_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: registered handshake, programmable wait states, byte/half/word
// lanes with load extension and error flagging. Optional counters under DMEM_STATS_EN.
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] err_count
`endif
);
    localparam int         WORDS     = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_t;

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            3'b010:  r = w;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    logic [31:0] mem [0:WORDS-1];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rd_q, rd_d, wr_q, wr_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  err_q, err_d;
    logic                  commit_s;

    logic                  a_rd_s, a_wr_s;
    logic [DM_ADDRESS-1:0] a_addr_s;
    logic [31:0]           a_wdata_s;
    logic [2:0]            a_f3_s;
    logic                  err_s, load_ok_s, store_ok_s;
    logic [3:0]            be_s;
    logic [31:0]           wlane_s, word_s;

    // Next-state, request latch and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        commit_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    rd_d    = bus.MemRead;
                    wr_d    = bus.MemWrite;
                    addr_d  = bus.addr;
                    wdata_d = bus.wr_data;
                    f3_d    = bus.func3;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = ST_RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d  = ST_RESP;
                    cnt_d    = 4'd0;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // Zero-wait commits straight from the bus, otherwise from the latched request.
    always_comb begin
        if (state_q == ST_IDLE) begin
            a_rd_s    = bus.MemRead;
            a_wr_s    = bus.MemWrite;
            a_addr_s  = bus.addr;
            a_wdata_s = bus.wr_data;
            a_f3_s    = bus.func3;
        end else begin
            a_rd_s    = rd_q;
            a_wr_s    = wr_q;
            a_addr_s  = addr_q;
            a_wdata_s = wdata_q;
            a_f3_s    = f3_q;
        end
    end

    // Access decode: error detection, store lanes and load result.
    always_comb begin
        err_s = (a_rd_s || a_wr_s) &&
                ((a_f3_s == 3'b011) || (a_f3_s == 3'b110) || (a_f3_s == 3'b111) ||
                 (a_wr_s && a_f3_s[2]) ||
                 ((a_f3_s[1:0] == 2'b01) && a_addr_s[0]) ||
                 ((a_f3_s == 3'b010) && (a_addr_s[1:0] != 2'b00)));
        store_ok_s = a_wr_s && !err_s;
        load_ok_s  = a_rd_s && !a_wr_s && !err_s;
        case (a_f3_s[1:0])
            2'b00: begin
                be_s    = 4'b0001 << a_addr_s[1:0];
                wlane_s = {4{a_wdata_s[7:0]}};
            end
            2'b01: begin
                be_s    = a_addr_s[1] ? 4'b1100 : 4'b0011;
                wlane_s = {2{a_wdata_s[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wlane_s = a_wdata_s;
            end
            default: begin
                be_s    = 4'b0000;
                wlane_s = 32'h0000_0000;
            end
        endcase
        word_s = mem[a_addr_s[DM_ADDRESS-1:2]];
        if (commit_s) begin
            rd_data_d = load_ok_s ? load_extract(word_s, a_addr_s[1:0], a_f3_s) : 32'h0000_0000;
            err_d     = err_s;
        end else begin
            rd_data_d = rd_data_q;
            err_d     = err_q;
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            f3_q        <= 3'b000;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rd_data_q   <= 32'h0000_0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
        end
    end

    // RAM contents survive reset; an edge coinciding with reset writes nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset && commit_s && store_ok_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem[a_addr_s[DM_ADDRESS-1:2]][b*8 +: 8] <= wlane_s[b*8 +: 8];
                end
            end
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.misaligned_err = err_q;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;

    // Saturating access counters, stepped on the commit edge.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (commit_s) begin
            if (load_ok_s && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
            else rd_cnt_d = rd_cnt_q;
            if (store_ok_s && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
            else wr_cnt_d = wr_cnt_q;
            if (err_s && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
            else err_cnt_d = err_cnt_q;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q  <= 16'h0000;
            wr_cnt_q  <= 16'h0000;
            err_cnt_q <= 16'h0000;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with WAIT_CYCLES=1.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    dmem_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

`ifdef DMEM_STATS_EN
    logic [15:0] rd_count, wr_count, err_count;
`endif

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
        bus.req_valid = v;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.addr      = a;
        bus.wr_data   = wd;
        bus.func3     = f3;
    endtask

    // One access with full handshake timing checks for WAIT_CYCLES=1.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [8:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        check_eq({tag, "/ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
        drive(1'b1, rd, wr, a, wd, f3);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
        @(negedge clk);
        check_eq({tag, "/rsp_early"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd0);
        @(negedge clk);
        check_eq({tag, "/rsp_strobe"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd2);
        check_eq({tag, "/rd_data"}, bus.rd_data, exp_rd);
        check_eq({tag, "/err"}, {31'd0, bus.misaligned_err}, {31'd0, exp_err});
        @(negedge clk);
        check_eq({tag, "/rsp_done"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    endtask

    logic [8:0]  t5_addr [3] = '{9'h010, 9'h011, 9'h012};
    logic [2:0]  t5_f3   [3] = '{3'b010, 3'b000, 3'b101};
    logic [31:0] t5_exp  [3] = '{32'h8001A5EF, 32'hFFFFFFA5, 32'h00008001};

    initial begin
        int          acc_cyc [3];
        logic [31:0] rsps [$];
        int          idx;
        int          ready_low;
        int          overlap;
        int          stray;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
        repeat (2) @(negedge clk);
        check_eq("reset/outputs", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);
        check_eq("reset/rd_data", bus.rd_data, 32'h0);
        check_eq("reset/err", {31'd0, bus.misaligned_err}, 32'd0);
        reset = 1'b0;

        access("sw_010", 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
        access("lw_010", 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
        access("sb_011", 1'b0, 1'b1, 9'h011, 32'h000000A5, 3'b000, 32'h0, 1'b0);
        access("lw_010b", 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADA5EF, 1'b0);
        access("lb_011", 1'b1, 1'b0, 9'h011, 32'h0, 3'b000, 32'hFFFFFFA5, 1'b0);
        access("lbu_011", 1'b1, 1'b0, 9'h011, 32'h0, 3'b100, 32'h000000A5, 1'b0);
        access("sh_012", 1'b0, 1'b1, 9'h012, 32'h00008001, 3'b001, 32'h0, 1'b0);
        access("lh_012", 1'b1, 1'b0, 9'h012, 32'h0, 3'b001, 32'hFFFF8001, 1'b0);
        access("lhu_012", 1'b1, 1'b0, 9'h012, 32'h0, 3'b101, 32'h00008001, 1'b0);
        access("lw_010c", 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 32'h8001A5EF, 1'b0);

        access("lw_013_mis", 1'b1, 1'b0, 9'h013, 32'h0, 3'b010, 32'h0, 1'b1);
        access("sw_014", 1'b0, 1'b1, 9'h014, 32'h0BADF00D, 3'b010, 32'h0, 1'b0);
        access("sw_016_mis", 1'b0, 1'b1, 9'h016, 32'h12345678, 3'b010, 32'h0, 1'b1);
        access("lw_014", 1'b1, 1'b0, 9'h014, 32'h0, 3'b010, 32'h0BADF00D, 1'b0);
        access("ld_f3_011", 1'b1, 1'b0, 9'h010, 32'h0, 3'b011, 32'h0, 1'b1);
        access("sb_f3_100", 1'b0, 1'b1, 9'h010, 32'h000000FF, 3'b100, 32'h0, 1'b1);
        access("rdwr_store", 1'b1, 1'b1, 9'h018, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0);
        access("lw_018", 1'b1, 1'b0, 9'h018, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);
        access("noop", 1'b0, 1'b0, 9'h010, 32'h0, 3'b010, 32'h0, 1'b0);

        // Back-to-back requests with req_valid held high.
        idx = 0; ready_low = 0; overlap = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsps.push_back(bus.rd_data);
            if (bus.rsp_valid && bus.req_ready) overlap++;
            if (!bus.req_ready) ready_low++;
            if (bus.req_ready) begin
                if (idx < 3) begin
                    drive(1'b1, 1'b1, 1'b0, t5_addr[idx], 32'h0, t5_f3[idx]);
                    acc_cyc[idx] = cyc;
                    idx++;
                end else begin
                    drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
                end
            end
        end
        check_eq("b2b/accepts", idx, 32'd3);
        check_eq("b2b/gap01", acc_cyc[1] - acc_cyc[0], 32'd3);
        check_eq("b2b/gap12", acc_cyc[2] - acc_cyc[1], 32'd3);
        check_eq("b2b/ready_low", ready_low, 32'd6);
        check_eq("b2b/overlap", overlap, 32'd0);
        check_eq("b2b/rsp_count", rsps.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("b2b/rsp%0d", i), (rsps.size() > i) ? rsps[i] : 32'hXXXXXXXX,
                     t5_exp[i]);
        end

        // Reset while a store sits in WAIT, held across its commit edge.
        access("sw_020", 1'b0, 1'b1, 9'h020, 32'h22222222, 3'b010, 32'h0, 1'b0);
        access("lw_020", 1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 32'h22222222, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 9'h020, 32'h11111111, 3'b010);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_mid/outputs", {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);
        check_eq("rst_mid/rd_data", bus.rd_data, 32'h0);
        check_eq("rst_mid/err", {31'd0, bus.misaligned_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) stray++;
        end
        check_eq("rst_mid/no_rsp", stray, 32'd0);
`ifdef DMEM_STATS_EN
        check_eq("stats/wr_after_rst", {16'd0, wr_count}, 32'd0);
        check_eq("stats/rd_after_rst", {16'd0, rd_count}, 32'd0);
`endif
        access("lw_020_after", 1'b1, 1'b0, 9'h020, 32'h0, 3'b010, 32'h22222222, 1'b0);
        access("lw_016_err", 1'b1, 1'b0, 9'h016, 32'h0, 3'b010, 32'h0, 1'b1);
`ifdef DMEM_STATS_EN
        check_eq("stats/rd_one", {16'd0, rd_count}, 32'd1);
        check_eq("stats/err_one", {16'd0, err_count}, 32'd1);
        check_eq("stats/wr_zero", {16'd0, wr_count}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
